// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types, RTC register map and index decoder for rtc_bus_sequencer.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_VADDR,
        S_VGAP1,
        S_VDATA,
        S_VGAP2,
        S_DONE
    } state_t;

    localparam logic [3:0] IDX_SEC    = 4'd0;
    localparam logic [3:0] IDX_MIN    = 4'd1;
    localparam logic [3:0] IDX_HOUR   = 4'd2;
    localparam logic [3:0] IDX_DAY    = 4'd3;
    localparam logic [3:0] IDX_MONTH  = 4'd4;
    localparam logic [3:0] IDX_YEAR   = 4'd5;
    localparam logic [3:0] IDX_TSEC   = 4'd6;
    localparam logic [3:0] IDX_TMIN   = 4'd7;
    localparam logic [3:0] IDX_THOUR  = 4'd8;
    localparam logic [3:0] IDX_STATUS = 4'd9;
    localparam logic [3:0] IDX_RAMCMD = 4'd10;

    localparam logic [7:0] RTC_SEC    = 8'h21;
    localparam logic [7:0] RTC_MIN    = 8'h22;
    localparam logic [7:0] RTC_HOUR   = 8'h23;
    localparam logic [7:0] RTC_DAY    = 8'h24;
    localparam logic [7:0] RTC_MONTH  = 8'h25;
    localparam logic [7:0] RTC_YEAR   = 8'h26;
    localparam logic [7:0] RTC_TSEC   = 8'h41;
    localparam logic [7:0] RTC_TMIN   = 8'h42;
    localparam logic [7:0] RTC_THOUR  = 8'h43;
    localparam logic [7:0] RTC_STATUS = 8'h02;
    localparam logic [7:0] RTC_RAMCMD = 8'hF0;

    // Returns {valid, rtc_addr}; indices 11..15 decode as invalid.
    function automatic logic [8:0] idx_to_rtc_addr(input logic [3:0] idx);
        case (idx)
            IDX_SEC:    return {1'b1, RTC_SEC};
            IDX_MIN:    return {1'b1, RTC_MIN};
            IDX_HOUR:   return {1'b1, RTC_HOUR};
            IDX_DAY:    return {1'b1, RTC_DAY};
            IDX_MONTH:  return {1'b1, RTC_MONTH};
            IDX_YEAR:   return {1'b1, RTC_YEAR};
            IDX_TSEC:   return {1'b1, RTC_TSEC};
            IDX_TMIN:   return {1'b1, RTC_TMIN};
            IDX_THOUR:  return {1'b1, RTC_THOUR};
            IDX_STATUS: return {1'b1, RTC_STATUS};
            IDX_RAMCMD: return {1'b1, RTC_RAMCMD};
            default:    return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Control handshake plus multiplexed RTC bus pins of rtc_bus_sequencer.
interface rtc_bus_if;

    logic       start;
    logic       rw;
    logic [3:0] Address_WR;
    logic [7:0] data_wr;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] data_rd;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output start, rw, Address_WR, data_wr, ad_in,
        input  busy, done, err, data_rd,
        input  cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );

    modport slave (
        input  start, rw, Address_WR, data_wr, ad_in,
        output busy, done, err, data_rd,
        output cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
    );

endinterface

// File: rtl/rtc_bus_sequencer_timer.sv
// rtc_phase_timer: loadable down-counter, tc high while the count is zero.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed A/D bus sequencer for the external RTC, one transaction at a time.
// Optional write readback check enabled by defining RTC_WR_VERIFY_EN.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSE = 10,
    parameter int T_GAP   = 5
) (
    input  logic     clk,
    input  logic     reset_n,
    rtc_bus_if.slave bus
);

    localparam int MAXT = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CW   = $clog2(MAXT) + 1;
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

    state_t          r_state;
    state_t          w_state_n;
    logic            r_rw;
    logic [7:0]      r_addr;
    logic [7:0]      r_wdata;
    logic            r_err;
    logic [7:0]      r_data_rd;
    logic [8:0]      w_map;
    logic            w_tc;
    logic            w_load;
    logic [CW-1:0]   w_val;
    logic            w_verify;

`ifdef RTC_WR_VERIFY_EN
    assign w_verify = r_rw;
`else
    assign w_verify = 1'b0;
`endif

    assign w_map = idx_to_rtc_addr(bus.Address_WR);

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_val   (w_val),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_state_n = w_map[8] ? S_ADDR : S_DONE;
            S_ADDR:  if (w_tc) w_state_n = S_GAP1;
            S_GAP1:  if (w_tc) w_state_n = S_DATA;
            S_DATA:  if (w_tc) w_state_n = S_GAP2;
            S_GAP2:  if (w_tc) w_state_n = w_verify ? S_VADDR : S_DONE;
            S_VADDR: if (w_tc) w_state_n = S_VGAP1;
            S_VGAP1: if (w_tc) w_state_n = S_VDATA;
            S_VDATA: if (w_tc) w_state_n = S_VGAP2;
            S_VGAP2: if (w_tc) w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Each phase restarts the shared timer on entry.
    always_comb begin
        w_load = (w_state_n != r_state);
        w_val  = '0;
        unique case (w_state_n)
            S_ADDR, S_DATA, S_VADDR, S_VDATA: w_val = LD_PULSE;
            S_GAP1, S_GAP2, S_VGAP1, S_VGAP2: w_val = LD_GAP;
            default:                          w_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_data_rd <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_rw    <= bus.rw;
                r_addr  <= w_map[7:0];
                r_wdata <= bus.data_wr;
                r_err   <= ~w_map[8];
            end
            if (r_state == S_DATA && w_tc && !r_rw) begin
                r_data_rd <= bus.ad_in;
            end
            if (r_state == S_VDATA && w_tc) begin
                r_data_rd <= bus.ad_in;
                if (bus.ad_in != r_wdata) r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.cs_n   = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.ad_sel = 1'b0;
        bus.ad_oe  = 1'b0;
        bus.ad_out = '0;
        unique case (r_state)
            S_ADDR, S_VADDR: begin
                bus.cs_n   = 1'b0;
                bus.wr_n   = 1'b0;
                bus.ad_oe  = 1'b1;
                bus.ad_out = r_addr;
            end
            S_GAP1, S_VGAP1: begin
                bus.ad_oe  = 1'b1;
                bus.ad_out = r_addr;
            end
            S_DATA: begin
                bus.cs_n   = 1'b0;
                bus.ad_sel = 1'b1;
                if (r_rw) begin
                    bus.wr_n   = 1'b0;
                    bus.ad_oe  = 1'b1;
                    bus.ad_out = r_wdata;
                end else begin
                    bus.rd_n   = 1'b0;
                    bus.ad_out = r_addr;
                end
            end
            S_VDATA: begin
                bus.cs_n   = 1'b0;
                bus.rd_n   = 1'b0;
                bus.ad_sel = 1'b1;
                bus.ad_out = r_addr;
            end
            S_GAP2: begin
                bus.ad_sel = 1'b1;
                bus.ad_out = r_rw ? r_wdata : r_addr;
            end
            S_VGAP2: begin
                bus.ad_sel = 1'b1;
                bus.ad_out = r_addr;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.err     = r_err;
    assign bus.data_rd = r_data_rd;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed table-driven bench for rtc_bus_sequencer at default timing.
module tb_rtc_bus_sequencer;

`ifdef RTC_WR_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    typedef struct {
        logic       rw;
        logic [3:0] idx;
        logic [7:0] wd;
        logic [7:0] adin;
        logic [7:0] eaddr;
        logic       ev;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd = 8'h00;

    rtc_bus_if bif ();

    rtc_bus_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int intr);
        int done_cyc = 0, ndone = 0, cs_cnt = 0, wr_cnt = 0, rd_cnt = 0;
        int first_cs = 0, bad_addr = 0, bad_data = 0, bad_oe = 0, bad_conf = 0;
        logic err_d = 1'b0, busy1 = 1'b0;
        logic [7:0] rd26 = 8'h00;
        bit vw;
        int e_done, e_cs, e_wr, e_rd;
        logic e_err;
        vw = VER && v.rw && v.ev;
        e_done = !v.ev ? 1 : (vw ? 61 : 31);
        e_cs   = !v.ev ? 0 : (vw ? 40 : 20);
        e_wr   = !v.ev ? 0 : (v.rw ? (vw ? 30 : 20) : 10);
        e_rd   = !v.ev ? 0 : (v.rw ? (vw ? 10 : 0) : 10);
        e_err  = !v.ev ? 1'b1 : (vw && (v.adin != v.wd));
        if (v.ev && (!v.rw || vw)) exp_rd = v.adin;

        @(posedge clk); #1;
        bif.start = 1'b1;
        bif.rw = v.rw;
        bif.Address_WR = v.idx;
        bif.data_wr = v.wd;
        bif.ad_in = v.adin;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (c == 1) bif.start = 1'b0;
            if (intr != 0 && c == intr) begin
                bif.start = 1'b1;
                bif.Address_WR = 4'd8;
                bif.data_wr = 8'hEE;
                bif.rw = ~v.rw;
            end
            if (intr != 0 && c == intr + 1) bif.start = 1'b0;
            if (c == 1) busy1 = bif.busy;
            if (!bif.cs_n) begin
                cs_cnt++;
                if (first_cs == 0) first_cs = c;
            end
            if (!bif.cs_n && !bif.ad_sel && bif.ad_out !== v.eaddr) bad_addr++;
            if (!bif.wr_n && bif.ad_sel && bif.ad_out !== v.wd) bad_data++;
            if (!bif.rd_n && bif.ad_oe) bad_oe++;
            if (!bif.rd_n && !bif.wr_n) bad_conf++;
            if ((!bif.rd_n || !bif.wr_n) && bif.cs_n) bad_conf++;
            if (!bif.wr_n) wr_cnt++;
            if (!bif.rd_n) rd_cnt++;
            if (bif.done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    err_d = bif.err;
                end
            end
            if (c == 26) rd26 = bif.data_rd;
        end
        chk($sformatf("idx%0d done_cyc", v.idx), done_cyc, e_done);
        chk($sformatf("idx%0d ndone", v.idx), ndone, 1);
        chk($sformatf("idx%0d err_at_done", v.idx), {31'd0, err_d}, {31'd0, e_err});
        chk($sformatf("idx%0d err_held", v.idx), {31'd0, bif.err}, {31'd0, e_err});
        chk($sformatf("idx%0d cs_cnt", v.idx), cs_cnt, e_cs);
        chk($sformatf("idx%0d wr_cnt", v.idx), wr_cnt, e_wr);
        chk($sformatf("idx%0d rd_cnt", v.idx), rd_cnt, e_rd);
        chk($sformatf("idx%0d first_cs", v.idx), first_cs, v.ev ? 1 : 0);
        chk($sformatf("idx%0d bad_addr", v.idx), bad_addr, 0);
        chk($sformatf("idx%0d bad_data", v.idx), bad_data, 0);
        chk($sformatf("idx%0d bad_oe", v.idx), bad_oe, 0);
        chk($sformatf("idx%0d bad_conf", v.idx), bad_conf, 0);
        chk($sformatf("idx%0d busy1", v.idx), {31'd0, busy1}, 32'd1);
        chk($sformatf("idx%0d busy_end", v.idx), {31'd0, bif.busy}, 32'd0);
        chk($sformatf("idx%0d data_rd", v.idx), {24'd0, bif.data_rd}, {24'd0, exp_rd});
        if (v.ev && !v.rw)
            chk($sformatf("idx%0d rd26", v.idx), {24'd0, rd26}, {24'd0, v.adin});
    endtask

    initial begin
        vec_t tbl[9];
        vec_t hv;
        tbl[0] = '{1'b1, 4'd1,  8'h45, 8'h45, 8'h22, 1'b1};
        tbl[1] = '{1'b0, 4'd7,  8'h00, 8'h59, 8'h42, 1'b1};
        tbl[2] = '{1'b1, 4'd12, 8'h33, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 4'd9,  8'h00, 8'hA5, 8'h02, 1'b1};
        tbl[4] = '{1'b1, 4'd10, 8'h3C, 8'h3C, 8'hF0, 1'b1};
        tbl[5] = '{1'b0, 4'd5,  8'h00, 8'h77, 8'h26, 1'b1};
        tbl[6] = '{1'b1, 4'd0,  8'h12, 8'h13, 8'h21, 1'b1};
        tbl[7] = '{1'b0, 4'd15, 8'h00, 8'hCC, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 4'd2,  8'h00, 8'h81, 8'h23, 1'b1};

        bif.start = 1'b0;
        bif.rw = 1'b0;
        bif.Address_WR = 4'd0;
        bif.data_wr = 8'h00;
        bif.ad_in = 8'h00;
        #1;
        chk("reset outs",
            {19'd0, bif.cs_n, bif.rd_n, bif.wr_n, bif.ad_sel, bif.ad_oe,
             bif.busy, bif.done, bif.err, 3'd0},
            {19'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        chk("reset ad_out", {24'd0, bif.ad_out}, 32'd0);
        chk("reset data_rd", {24'd0, bif.data_rd}, 32'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 9; i++) do_txn(tbl[i], 0);

        // Start pulse mid-transaction must be ignored.
        hv = '{1'b1, 4'd3, 8'h5A, 8'h5A, 8'h24, 1'b1};
        do_txn(hv, 5);

        // Asynchronous reset in the middle of a write data phase.
        @(posedge clk); #1;
        bif.start = 1'b1;
        bif.rw = 1'b1;
        bif.Address_WR = 4'd4;
        bif.data_wr = 8'h99;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c == 1) bif.start = 1'b0;
        end
        chk("pre-reset wr_n", {31'd0, bif.wr_n}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid-reset strobes", {29'd0, bif.cs_n, bif.rd_n, bif.wr_n}, 32'd7);
        chk("mid-reset busy", {31'd0, bif.busy}, 32'd0);
        chk("mid-reset ad_oe", {31'd0, bif.ad_oe}, 32'd0);
        chk("mid-reset data_rd", {24'd0, bif.data_rd}, 32'd0);
        exp_rd = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        hv = '{1'b0, 4'd6, 8'h00, 8'h31, 8'h41, 1'b1};
        do_txn(hv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
